// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle RV32 core: opcodes, funct3 values,
// FSM state and ALU operation enums, and the immediate generator.
package cpu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, WRITEBACK, HALT
  } cpu_state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // Sign-extended immediate selected by instruction format.
  function automatic logic [31:0] imm_gen(input logic [31:0] ir);
    case (ir[6:0])
      OPC_LUI, OPC_AUIPC: return {ir[31:12], 12'b0};
      OPC_JAL:            return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      OPC_BRANCH:         return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_STORE:          return {{21{ir[31]}}, ir[30:25], ir[11:7]};
      default:            return {{21{ir[31]}}, ir[30:20]};
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational integer ALU plus the compare flags used by branches.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] result_o,
  output logic        eq_o,
  output logic        lt_o,
  output logic        ltu_o
);

  logic [4:0] sh;

  assign sh    = b_i[4:0];
  assign eq_o  = a_i == b_i;
  assign lt_o  = $signed(a_i) < $signed(b_i);
  assign ltu_o = a_i < b_i;

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << sh;
      ALU_SLT:  result_o = {31'b0, lt_o};
      ALU_SLTU: result_o = {31'b0, ltu_o};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> sh;
      ALU_SRA:  result_o = $signed(a_i) >>> sh;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mc.sv
// Multicycle RV32I/E core: FETCH/DECODE/EXECUTE/WRITEBACK with a stallable
// valid/ready store port and a terminal HALT on illegal or misaligned work.
module cpu_mc
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          NUM_REGS      = 32,
  parameter bit          STORE_WORD_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_addr_o,
  output logic [31:0] out_data_o,
  output logic [3:0]  out_strb_o,
  output logic        halted_o
);

  localparam int         RW   = $clog2(NUM_REGS);
  localparam logic [5:0] NREG = 6'(NUM_REGS);

  cpu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q;
  logic [31:0] rf_q [NUM_REGS];

  logic [31:0] a_q, b_q, imm_q, rs2v_q, res_q, npc_q;
  alu_op_e     op_q;
  logic        is_br_q, is_jal_q, is_jalr_q, is_st_q, wr_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] st_addr_q, st_data_q;
  logic [3:0]  st_strb_q;

  // Decode fields
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1v, rs2v, imm;
  logic        legal, use_rs1, use_rs2, use_rd;
  alu_op_e     dec_op;

  assign opc  = ir_q[6:0];
  assign rd   = ir_q[11:7];
  assign f3   = ir_q[14:12];
  assign rs1  = ir_q[19:15];
  assign rs2  = ir_q[24:20];
  assign f7   = ir_q[31:25];
  assign imm  = imm_gen(ir_q);
  assign rs1v = (rs1 == 5'd0) ? '0 : rf_q[rs1[RW-1:0]];
  assign rs2v = (rs2 == 5'd0) ? '0 : rf_q[rs2[RW-1:0]];

  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        legal  = 1'b1;
        use_rd = 1'b1;
      end
      OPC_JALR: begin
        legal   = f3 == 3'b000;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        legal   = f3 != 3'b010 && f3 != 3'b011;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_STORE: begin
        legal   = f3 == F3_SB || (STORE_WORD_EN && (f3 == F3_SH || f3 == F3_SW));
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        legal   = (f3 == F3_SLL) ? f7 == 7'h00 :
                  (f3 == F3_SR)  ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_OP: begin
        legal   = f7 == 7'h00 || (f7 == 7'h20 && (f3 == F3_ADD || f3 == F3_SR));
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
    if ((use_rs1 && {1'b0, rs1} >= NREG) || (use_rs2 && {1'b0, rs2} >= NREG) ||
        (use_rd && {1'b0, rd} >= NREG))
      legal = 1'b0;
  end

  // Only register/immediate ALU instructions use funct3; everything else adds.
  always_comb begin
    dec_op = ALU_ADD;
    if (opc == OPC_OP || opc == OPC_OP_IMM) begin
      case (f3)
        F3_ADD:  dec_op = (opc == OPC_OP && f7[5]) ? ALU_SUB : ALU_ADD;
        F3_SLL:  dec_op = ALU_SLL;
        F3_SLT:  dec_op = ALU_SLT;
        F3_SLTU: dec_op = ALU_SLTU;
        F3_XOR:  dec_op = ALU_XOR;
        F3_SR:   dec_op = f7[5] ? ALU_SRA : ALU_SRL;
        F3_OR:   dec_op = ALU_OR;
        default: dec_op = ALU_AND;
      endcase
    end
  end

  // Execute
  logic [31:0] alu_res, pc4, tgt, nxt, st_data;
  logic        eq, lt, ltu, br_cond, redirect, jump_bad, st_bad;
  logic [3:0]  st_strb;

  cpu_alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_res),
    .eq_o     (eq),
    .lt_o     (lt),
    .ltu_o    (ltu)
  );

  always_comb begin
    case (f3_q)
      F3_BEQ:  br_cond = eq;
      F3_BNE:  br_cond = !eq;
      F3_BLT:  br_cond = lt;
      F3_BGE:  br_cond = !lt;
      F3_BLTU: br_cond = ltu;
      F3_BGEU: br_cond = !ltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign pc4      = pc_q + 32'd4;
  assign tgt      = is_jalr_q ? {alu_res[31:1], 1'b0} : pc_q + imm_q;
  assign redirect = is_jal_q || is_jalr_q || (is_br_q && br_cond);
  assign nxt      = redirect ? tgt : pc4;
  assign jump_bad = redirect && tgt[1];
  assign st_bad   = is_st_q && ((f3_q == F3_SH && alu_res[0]) ||
                                (f3_q == F3_SW && alu_res[1:0] != 2'b00));

  always_comb begin
    case (f3_q)
      F3_SB: begin
        st_strb = 4'b0001 << alu_res[1:0];
        st_data = {24'b0, rs2v_q[7:0]};
      end
      F3_SH: begin
        st_strb = 4'b0011 << alu_res[1:0];
        st_data = {16'b0, rs2v_q[15:0]};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = rs2v_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      FETCH:     state_d = DECODE;
      DECODE:    state_d = legal ? EXECUTE : HALT;
      EXECUTE:   state_d = (jump_bad || st_bad) ? HALT : WRITEBACK;
      WRITEBACK: if (!is_st_q || out_ready_i) begin
        state_d = FETCH;
        pc_d    = npc_q;
      end
      default:   state_d = HALT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      rs2v_q    <= '0;
      op_q      <= ALU_ADD;
      is_br_q   <= 1'b0;
      is_jal_q  <= 1'b0;
      is_jalr_q <= 1'b0;
      is_st_q   <= 1'b0;
      wr_q      <= 1'b0;
      f3_q      <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      npc_q     <= '0;
      st_addr_q <= '0;
      st_data_q <= '0;
      st_strb_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      case (state_q)
        FETCH: ir_q <= imem_rdata_i;
        DECODE: begin
          a_q       <= (opc == OPC_LUI) ? '0 : (opc == OPC_AUIPC) ? pc_q : rs1v;
          b_q       <= (opc == OPC_OP || opc == OPC_BRANCH) ? rs2v : imm;
          imm_q     <= imm;
          rs2v_q    <= rs2v;
          op_q      <= dec_op;
          is_br_q   <= opc == OPC_BRANCH;
          is_jal_q  <= opc == OPC_JAL;
          is_jalr_q <= opc == OPC_JALR;
          is_st_q   <= opc == OPC_STORE;
          wr_q      <= use_rd && rd != 5'd0;
          f3_q      <= f3;
          rd_q      <= rd;
        end
        EXECUTE: begin
          res_q <= (is_jal_q || is_jalr_q) ? pc4 : alu_res;
          npc_q <= nxt;
          // Store payload is captured once here so it stays stable while stalled.
          if (is_st_q) begin
            st_addr_q <= alu_res;
            st_data_q <= st_data;
            st_strb_q <= st_strb;
          end
        end
        WRITEBACK:
          if (state_d == FETCH && wr_q) rf_q[rd_q[RW-1:0]] <= res_q;
        default: ;
      endcase
    end
  end

  assign imem_addr_o = pc_q;
  assign out_valid_o = state_q == WRITEBACK && is_st_q;
  assign out_addr_o  = st_addr_q;
  assign out_data_o  = st_data_q;
  assign out_strb_o  = st_strb_q;
  assign halted_o    = state_q == HALT;

endmodule
